// File: rtl/cell_sweep_tester.sv
// cell_sweep_tester: exhaustive truth-table sweep of one selected standard cell.
// Every input vector is driven onto stim_o and held for a fixed settle time.
// The selected cell's Y is then sampled and compared against an expected truth
// table. Mismatches are counted (saturating), and the first failing vector is
// recorded. One pass covers all 2^n vectors. Loop mode repeats passes until a
// stop request has been seen.
module cell_sweep_tester #(
  parameter int NUM_CELLS     = 16,
  parameter int NUM_IN        = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 16
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic                         start_i,
  input  logic                         loop_i,
  input  logic                         stop_i,
  input  logic [$clog2(NUM_CELLS)-1:0] cell_sel_i,
  input  logic [$clog2(NUM_IN):0]      n_inputs_i,
  input  logic [2**NUM_IN-1:0]         truth_i,
  input  logic [NUM_CELLS-1:0]         cell_y_i,
  output logic [NUM_IN-1:0]            stim_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [ERR_W-1:0]             err_cnt_o,
  output logic                         fail_valid_o,
  output logic [NUM_IN-1:0]            fail_vec_o
);

  localparam int SEL_W = $clog2(NUM_CELLS);
  localparam int NIN_W = $clog2(NUM_IN) + 1;
  localparam int TT_W  = 2 ** NUM_IN;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_IN-1:0] vec_q, vec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NIN_W-1:0]  n_q, n_d;
  logic [TT_W-1:0]   truth_q, truth_d;
  logic              loop_q, loop_d;
  logic              stop_q, stop_d;
  logic [NUM_IN-1:0] stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fail_valid_q, fail_valid_d;
  logic [NUM_IN-1:0] fail_vec_q, fail_vec_d;

  logic [NUM_IN-1:0] vec_mask;
  logic              sample_y;
  logic              mismatch;

  // Mask of active stimulus bits; it also equals the last vector of a pass.
  always_comb begin
    vec_mask = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      vec_mask[i] = (i < int'(n_q));
    end
  end

  // Selected cell output; out-of-range selections read as 0.
  always_comb begin
    sample_y = 1'b0;
    if (int'(sel_q) < NUM_CELLS) begin
      sample_y = cell_y_i[sel_q];
    end
    mismatch = (sample_y != truth_q[vec_q]);
  end

  // Next-state logic for the sweep FSM and all registered outputs.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path can infer a latch.
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    n_d          = n_q;
    truth_d      = truth_q;
    loop_d       = loop_q;
    stop_d       = stop_q;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sel_d   = cell_sel_i;
          truth_d = truth_i;
          loop_d  = loop_i;
          if (n_inputs_i == '0) begin
            n_d = NIN_W'(1);
          end else if (int'(n_inputs_i) > NUM_IN) begin
            n_d = NIN_W'(NUM_IN);
          end else begin
            n_d = n_inputs_i;
          end
          stop_d       = 1'b0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
          vec_d        = '0;
          state_d      = S_APPLY;
        end
      end
      S_APPLY: begin
        cnt_d   = CNT_W'(SETTLE_CYCLES);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + ERR_W'(1);
          end
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end
        end
        if (vec_q == vec_mask) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + NUM_IN'(1);
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        if (loop_q && !stop_i && !stop_q) begin
          vec_d   = '0;
          state_d = S_APPLY;
        end else begin
          pass_d  = (err_q == '0);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Sticky stop request, only meaningful for a running loop-mode test.
    if (state_q != S_IDLE && loop_q && stop_i) begin
      stop_d = 1'b1;
    end

    // Outputs are registered, so they are derived from the next state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if (state_d == S_APPLY) begin
      stim_d = vec_d & vec_mask;
    end else if (state_d == S_IDLE) begin
      stim_d = '0;
    end else begin
      stim_d = stim_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q      <= S_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      sel_q        <= '0;
      n_q          <= NIN_W'(1);
      truth_q      <= '0;
      loop_q       <= 1'b0;
      stop_q       <= 1'b0;
      stim_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      n_q          <= n_d;
      truth_q      <= truth_d;
      loop_q       <= loop_d;
      stop_q       <= stop_d;
      stim_q       <= stim_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
    end
  end

  assign stim_o       = stim_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_cnt_o    = err_q;
  assign fail_valid_o = fail_valid_q;
  assign fail_vec_o   = fail_vec_q;

endmodule

// File: tb/tb_cell_sweep_tester.sv
// Self-checking bench for cell_sweep_tester. Cell outputs come from per-cell
// lookup tables indexed by the stimulus bus. Expected results are computed from
// the sweep rules: vector count, per-pass mismatch count and pass lengths.
module tb_cell_sweep_tester;

  localparam int SETTLE = 4;
  localparam int VLEN   = SETTLE + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        loop = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  sel = '0;
  logic [2:0]  nin = '0;
  logic [15:0] truth = '0;
  logic [15:0] cell_y;
  logic [3:0]  stim;
  logic        busy, done, pass;
  logic [15:0] err;
  logic        fv;
  logic [3:0]  fvec;
  logic [3:0]  stim_s;
  logic        busy_s, done_s, pass_s;
  logic [1:0]  err_s;
  logic        fv_s;
  logic [3:0]  fvec_s;

  logic [15:0] tbl [16];

  int tests_run = 0;
  int tests_failed = 0;

  int obs_done_cnt;
  int obs_done_t[$];
  int obs_stim_bad;
  int obs_end_t;

  always #5 clk = ~clk;

  // Each cell is a lookup table over the stimulus bus.
  always_comb begin
    cell_y = '0;
    for (int c = 0; c < 16; c++) cell_y[c] = tbl[c][stim];
  end

  cell_sweep_tester #(.NUM_CELLS(16), .NUM_IN(4), .SETTLE_CYCLES(SETTLE), .ERR_W(16)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .loop_i(loop), .stop_i(stop),
    .cell_sel_i(sel), .n_inputs_i(nin), .truth_i(truth), .cell_y_i(cell_y),
    .stim_o(stim), .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err),
    .fail_valid_o(fv), .fail_vec_o(fvec)
  );

  cell_sweep_tester #(.NUM_CELLS(16), .NUM_IN(4), .SETTLE_CYCLES(SETTLE), .ERR_W(2)) u_sat (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .loop_i(loop), .stop_i(stop),
    .cell_sel_i(sel), .n_inputs_i(nin), .truth_i(truth), .cell_y_i(cell_y),
    .stim_o(stim_s), .busy_o(busy_s), .done_o(done_s), .pass_o(pass_s), .err_cnt_o(err_s),
    .fail_valid_o(fv_s), .fail_vec_o(fvec_s)
  );

  function automatic int clamp_n(input int n);
    if (n < 1) return 1;
    if (n > 4) return 4;
    return n;
  endfunction

  function automatic int count_err(input int s, input int n, input logic [15:0] tr);
    int cnt = 0;
    for (int v = 0; v < (1 << n); v++) if (tbl[s][v] != tr[v]) cnt++;
    return cnt;
  endfunction

  function automatic int first_err(input int s, input int n, input logic [15:0] tr);
    for (int v = 0; v < (1 << n); v++) if (tbl[s][v] != tr[v]) return v;
    return -1;
  endfunction

  function automatic logic [15:0] nand2_tbl();
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = ~(v[0] & v[1]);
    return t;
  endfunction

  // Starts a run with the current configuration and records what the DUT does
  // until busy drops: done pulse times, stimulus deviations and run length.
  task automatic run(input bit lp, input int stop_at, input int start_at, input bit scramble);
    int t, nvec, plen, p;
    nvec = 1 << clamp_n(int'(nin));
    plen = nvec * VLEN + 1;
    obs_done_cnt = 0;
    obs_done_t.delete();
    obs_stim_bad = 0;
    loop = lp;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (busy) begin
      if (done) begin
        obs_done_cnt++;
        obs_done_t.push_back(t);
      end
      p = t % plen;
      if (p < nvec * VLEN && stim !== 4'(p / VLEN)) obs_stim_bad++;
      stop = (t == stop_at);
      start = (t == start_at);
      if (scramble) begin
        sel = 4'($urandom);
        nin = 3'($urandom);
        truth = 16'($urandom);
        loop = 1'($urandom);
      end
      @(posedge clk); #1;
      t++;
      if (t > 5000) break;
    end
    stop = 1'b0;
    start = 1'b0;
    obs_end_t = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (stim !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ctrl: got stim=%0d busy=%b done=%b expected 0/0/0", stim, busy, done);
    end
    tests_run++;
    if (pass !== 1'b0 || err !== 16'd0 || fv !== 1'b0 || fvec !== 4'd0) begin
      tests_failed++; $display("FAIL reset_result: got pass=%b err=%0d fv=%b fvec=%0d expected all 0", pass, err, fv, fvec);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_nand2_pass();
    tbl[0] = nand2_tbl();
    sel = 4'd0; nin = 3'd2;
    truth = {12'($urandom), 4'b0111};
    run(1'b0, -1, -1, 1'b0);
    tests_run++;
    if (obs_stim_bad !== 0) begin tests_failed++; $display("FAIL nand2_stim: got %0d bad cycles expected 0", obs_stim_bad); end
    tests_run++;
    if (obs_done_cnt !== 1 || obs_done_t.size() < 1 || obs_done_t[0] !== 24) begin
      tests_failed++; $display("FAIL nand2_done: got %0d pulses first at %0d expected 1 at 24", obs_done_cnt, obs_done_t.size() > 0 ? obs_done_t[0] : -1);
    end
    tests_run++;
    if (obs_end_t !== 25) begin tests_failed++; $display("FAIL nand2_len: got %0d expected 25", obs_end_t); end
    tests_run++;
    if (pass !== 1'b1 || err !== 16'd0 || fv !== 1'b0) begin
      tests_failed++; $display("FAIL nand2_result: got pass=%b err=%0d fv=%b expected 1/0/0", pass, err, fv);
    end
  endtask

  task automatic test_fault_injection();
    tbl[0] = 16'hFFFF;
    sel = 4'd0; nin = 3'd2;
    truth = {12'($urandom), 4'b0111};
    run(1'b0, -1, -1, 1'b0);
    tests_run++;
    if (err !== 16'd1 || fv !== 1'b1 || fvec !== 4'd3 || pass !== 1'b0) begin
      tests_failed++; $display("FAIL stuck1: got err=%0d fv=%b fvec=%0d pass=%b expected 1/1/3/0", err, fv, fvec, pass);
    end
  endtask

  task automatic test_clamp_mask();
    int e, f;
    tbl[7] = 16'($urandom);
    sel = 4'd7; nin = 3'd0;
    truth = 16'($urandom);
    e = count_err(7, 1, truth); f = first_err(7, 1, truth);
    run(1'b0, -1, -1, 1'b0);
    tests_run++;
    if (obs_end_t !== 2 * VLEN + 1 || obs_stim_bad !== 0) begin
      tests_failed++; $display("FAIL clamp0: got len=%0d bad=%0d expected %0d/0", obs_end_t, obs_stim_bad, 2 * VLEN + 1);
    end
    tests_run++;
    if (err !== 16'(e) || fvec !== 4'(e > 0 ? f : 0)) begin
      tests_failed++; $display("FAIL clamp0_err: got err=%0d fvec=%0d expected %0d/%0d", err, fvec, e, e > 0 ? f : 0);
    end
    nin = 3'd7;
    truth = 16'($urandom);
    e = count_err(7, 4, truth); f = first_err(7, 4, truth);
    run(1'b0, -1, -1, 1'b0);
    tests_run++;
    if (obs_end_t !== 16 * VLEN + 1 || obs_stim_bad !== 0) begin
      tests_failed++; $display("FAIL clamp7: got len=%0d bad=%0d expected %0d/0", obs_end_t, obs_stim_bad, 16 * VLEN + 1);
    end
    tests_run++;
    if (err !== 16'(e) || pass !== (e == 0)) begin
      tests_failed++; $display("FAIL clamp7_err: got err=%0d pass=%b expected %0d/%b", err, pass, e, e == 0);
    end
  endtask

  task automatic test_loop_stop();
    tbl[5] = 16'h0000;
    sel = 4'd5; nin = 3'd2;
    truth = {12'($urandom), 4'b1000};
    run(1'b1, 60, -1, 1'b0);
    tests_run++;
    if (obs_done_cnt !== 3 || obs_done_t.size() < 3 || obs_done_t[2] !== 74) begin
      tests_failed++; $display("FAIL loop_done: got %0d pulses expected 3 with last at 74", obs_done_cnt);
    end
    tests_run++;
    if (obs_end_t !== 75 || obs_stim_bad !== 0) begin
      tests_failed++; $display("FAIL loop_len: got len=%0d bad=%0d expected 75/0", obs_end_t, obs_stim_bad);
    end
    tests_run++;
    if (err !== 16'd3 || fvec !== 4'd3 || pass !== 1'b0) begin
      tests_failed++; $display("FAIL loop_err: got err=%0d fvec=%0d pass=%b expected 3/3/0", err, fvec, pass);
    end
  endtask

  task automatic test_saturation();
    tbl[2] = 16'h0000;
    sel = 4'd2; nin = 3'd2;
    truth = {12'($urandom), 4'b1110};
    run(1'b1, 30, -1, 1'b0);
    tests_run++;
    if (obs_done_cnt !== 2 || obs_end_t !== 50) begin
      tests_failed++; $display("FAIL sat_passes: got %0d pulses len=%0d expected 2/50", obs_done_cnt, obs_end_t);
    end
    tests_run++;
    if (err_s !== 2'd3 || fvec_s !== 4'd1 || pass_s !== 1'b0) begin
      tests_failed++; $display("FAIL sat_err: got err=%0d fvec=%0d pass=%b expected 3/1/0", err_s, fvec_s, pass_s);
    end
    tests_run++;
    if (err !== 16'd6) begin tests_failed++; $display("FAIL sat_wide: got %0d expected 6", err); end
  endtask

  task automatic test_reset_midrun();
    tbl[1] = 16'h0000;
    sel = 4'd1; nin = 3'd2;
    truth = {12'($urandom), 4'b0111};
    loop = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    tests_run++;
    if (err !== 16'd2 || fv !== 1'b1 || fvec !== 4'd0 || busy !== 1'b1 || stim !== 4'd2) begin
      tests_failed++; $display("FAIL midrun_pre: got err=%0d fv=%b fvec=%0d busy=%b stim=%0d expected 2/1/0/1/2", err, fv, fvec, busy, stim);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (stim !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err !== 16'd0 || fv !== 1'b0 || fvec !== 4'd0) begin
      tests_failed++; $display("FAIL midrun_reset: got stim=%0d busy=%b err=%0d fv=%b expected all 0", stim, busy, err, fv);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrun_idle: got busy=%b expected 0", busy); end
    run(1'b0, -1, -1, 1'b0);
    tests_run++;
    if (err !== 16'd3 || fvec !== 4'd0 || obs_end_t !== 25) begin
      tests_failed++; $display("FAIL midrun_rerun: got err=%0d fvec=%0d len=%0d expected 3/0/25", err, fvec, obs_end_t);
    end
  endtask

  task automatic test_start_robust();
    int n, e, f;
    tbl[3] = 16'($urandom);
    sel = 4'd3; nin = 3'($urandom_range(1, 4));
    truth = 16'($urandom);
    n = clamp_n(int'(nin));
    e = count_err(3, n, truth); f = first_err(3, n, truth);
    run(1'b0, -1, 7, 1'b1);
    tests_run++;
    if (obs_end_t !== (1 << n) * VLEN + 1 || obs_done_cnt !== 1 || obs_stim_bad !== 0) begin
      tests_failed++; $display("FAIL restart_len: got len=%0d pulses=%0d bad=%0d expected %0d/1/0", obs_end_t, obs_done_cnt, obs_stim_bad, (1 << n) * VLEN + 1);
    end
    tests_run++;
    if (err !== 16'(e) || fvec !== 4'(e > 0 ? f : 0) || pass !== (e == 0)) begin
      tests_failed++; $display("FAIL restart_err: got err=%0d fvec=%0d pass=%b expected %0d/%0d/%b", err, fvec, pass, e, e > 0 ? f : 0, e == 0);
    end
  endtask

  task automatic test_back_to_back();
    int t;
    tbl[0] = nand2_tbl();
    sel = 4'd0; nin = 3'd1;
    truth = {14'($urandom), 2'b11};
    loop = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    t = 0;
    while (busy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    tests_run++;
    if (t !== 2 * VLEN + 1 || pass !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_first: got len=%0d pass=%b expected %0d/1", t, pass, 2 * VLEN + 1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || stim !== 4'd0 || pass !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_restart: got busy=%b stim=%0d pass=%b expected 1/0/0", busy, stim, pass);
    end
    t = 0;
    while (busy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    tests_run++;
    if (t !== 2 * VLEN + 1 || pass !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_second: got len=%0d pass=%b expected %0d/1", t, pass, 2 * VLEN + 1);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int s, n, e, f, passes, plen, stop_at, exp_err;
      bit lp;
      for (int c = 0; c < 16; c++) tbl[c] = 16'($urandom);
      s = $urandom_range(0, 15);
      sel = 4'(s);
      nin = 3'($urandom_range(0, 7));
      truth = 16'($urandom);
      n = clamp_n(int'(nin));
      e = count_err(s, n, truth);
      f = first_err(s, n, truth);
      lp = 1'($urandom_range(0, 1));
      passes = lp ? $urandom_range(1, 3) : 1;
      plen = (1 << n) * VLEN + 1;
      stop_at = (passes - 1) * plen + $urandom_range(0, plen - 1);
      exp_err = passes * e;
      run(lp, stop_at, -1, 1'b0);
      tests_run++;
      if (obs_done_cnt !== passes || obs_end_t !== passes * plen || obs_stim_bad !== 0) begin
        tests_failed++; $display("FAIL rand%0d_len: got pulses=%0d len=%0d bad=%0d expected %0d/%0d/0", it, obs_done_cnt, obs_end_t, obs_stim_bad, passes, passes * plen);
      end
      tests_run++;
      if (err !== 16'(exp_err) || fv !== (e > 0) || fvec !== 4'(e > 0 ? f : 0)) begin
        tests_failed++; $display("FAIL rand%0d_err: got err=%0d fv=%b fvec=%0d expected %0d/%b/%0d", it, err, fv, fvec, exp_err, e > 0, e > 0 ? f : 0);
      end
      tests_run++;
      if (pass !== (e == 0) || err_s !== 2'(exp_err > 3 ? 3 : exp_err)) begin
        tests_failed++; $display("FAIL rand%0d_pass: got pass=%b sat=%0d expected %b/%0d", it, pass, err_s, e == 0, exp_err > 3 ? 3 : exp_err);
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 16; c++) tbl[c] = '0;
    test_reset();
    test_nand2_pass();
    test_fault_injection();
    test_clamp_mask();
    test_loop_stop();
    test_saturation();
    test_reset_midrun();
    test_start_robust();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
